mcm_8_pipe: RTL and testbench

- Parametrised, handshaked successor of the 8-point odd-part multiple-constant-multiplication stage used by the 16-point DCT/IDCT butterfly in the tq pipeline.
- Multiplies an 8-element vector by the fixed 8x8 odd-coefficient matrix C (forward mode) or by its transpose (inverse mode). Mode is selectable per beat.
- Adds valid/ready flow control, optional rounding right-shift, output saturation and a synchronous flush.
- Sits between the even/odd butterfly split and the recombination adder in both the forward and inverse transform paths.

---
 rtl/tq_pkg.sv | 76 +++++++
 rtl/spiral_8_p.sv | 37 +++
 rtl/mcm_8_pipe.sv | 152 +++++++++++++++
 tb/tb_mcm_8_pipe.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tq_pkg.sv
// Shared transform constants: odd-part DCT coefficients, the 8x8
// coefficient index/sign table and the round/saturate helper.
package tq_pkg;

  localparam int COEF_9  = 9;
  localparam int COEF_25 = 25;
  localparam int COEF_43 = 43;
  localparam int COEF_57 = 57;
  localparam int COEF_70 = 70;
  localparam int COEF_80 = 80;
  localparam int COEF_87 = 87;
  localparam int COEF_90 = 90;

  typedef struct packed {
    logic valid;
    logic inverse;
  } beat_ctl_t;

  // Index into {9,25,43,57,70,80,87,90} for C[k][j].
  function automatic logic [2:0] coef_idx(input int k, input int j);
    logic [0:7][2:0] r;
    r = '0;
    unique case (k)
      0: r = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      1: r = {3'd1, 3'd4, 3'd7, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6};
      2: r = {3'd2, 3'd7, 3'd3, 3'd1, 3'd6, 3'd4, 3'd0, 3'd5};
      3: r = {3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2, 3'd4};
      4: r = {3'd4, 3'd2, 3'd6, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3};
      5: r = {3'd5, 3'd0, 3'd4, 3'd6, 3'd1, 3'd3, 3'd7, 3'd2};
      6: r = {3'd6, 3'd3, 3'd0, 3'd2, 3'd5, 3'd7, 3'd4, 3'd1};
      7: r = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      default: r = '0;
    endcase
    return r[j];
  endfunction

  // Sign of C[k][j]: 1 = negative.
  function automatic logic coef_neg(input int k, input int j);
    logic [0:7] s;
    s = '0;
    unique case (k)
      0: s = 8'b00000000;
      1: s = 8'b11111000;
      2: s = 8'b00011100;
      3: s = 8'b11000110;
      4: s = 8'b00110110;
      5: s = 8'b10010010;
      6: s = 8'b01001010;
      7: s = 8'b10101010;
      default: s = '0;
    endcase
    return s[j];
  endfunction

  // Round-half-up arithmetic shift, then clamp to out_w signed range.
  function automatic logic signed [63:0] sat_rnd(
    input logic signed [63:0] sum,
    input int                 shift,
    input int                 out_w
  );
    logic signed [63:0] r;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    r = sum;
    if (shift > 0)
      r = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
    mx = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (out_w - 1));
    if (r > mx)
      r = mx;
    else if (r < mn)
      r = mn;
    return r;
  endfunction

endpackage

// File: rtl/spiral_8_p.sv
// Shift-add generator of x*{9,25,43,57,70,80,87,90}.
// x: signed input; m[i]: product for coefficient i, IN_W+7 bits.
module spiral_8_p #(
  parameter int IN_W = 18
) (
  input  logic signed [IN_W-1:0]    x,
  output logic [7:0][IN_W+6:0]      m
);

  localparam int MW = IN_W + 7;

  logic signed [MW-1:0] x1;
  logic signed [MW-1:0] x2;
  logic signed [MW-1:0] x4;
  logic signed [MW-1:0] x8;
  logic signed [MW-1:0] x16;
  logic signed [MW-1:0] x32;
  logic signed [MW-1:0] x64;

  assign x1  = MW'(x);
  assign x2  = x1 <<< 1;
  assign x4  = x1 <<< 2;
  assign x8  = x1 <<< 3;
  assign x16 = x1 <<< 4;
  assign x32 = x1 <<< 5;
  assign x64 = x1 <<< 6;

  assign m[0] = x8 + x1;
  assign m[1] = x16 + x8 + x1;
  assign m[2] = x32 + x8 + x2 + x1;
  assign m[3] = x64 - x8 + x1;
  assign m[4] = x64 + x4 + x2;
  assign m[5] = x64 + x16;
  assign m[6] = x64 + x16 + x8 - x1;
  assign m[7] = x64 + x16 + x8 + x2;

endmodule

// File: rtl/mcm_8_pipe.sv
// 8-point odd-part MCM stage: o = C*i (fwd) or C^T*i (inv), 3 stages,
// valid/ready flow, rounding shift, saturation, sync flush.
module mcm_8_pipe
  import tq_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int SHIFT = 0,
  parameter int OUT_W = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic                    i_inverse,
  input  logic signed [IN_W-1:0]  i_0,
  input  logic signed [IN_W-1:0]  i_1,
  input  logic signed [IN_W-1:0]  i_2,
  input  logic signed [IN_W-1:0]  i_3,
  input  logic signed [IN_W-1:0]  i_4,
  input  logic signed [IN_W-1:0]  i_5,
  input  logic signed [IN_W-1:0]  i_6,
  input  logic signed [IN_W-1:0]  i_7,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [OUT_W-1:0] o_0,
  output logic signed [OUT_W-1:0] o_1,
  output logic signed [OUT_W-1:0] o_2,
  output logic signed [OUT_W-1:0] o_3,
  output logic signed [OUT_W-1:0] o_4,
  output logic signed [OUT_W-1:0] o_5,
  output logic signed [OUT_W-1:0] o_6,
  output logic signed [OUT_W-1:0] o_7
);

  localparam int ACC_W = IN_W + 10;
  localparam int PW    = ACC_W - 1;
  localparam int MW    = IN_W + 7;

  logic                 advance;
  logic signed [IN_W-1:0] x [8];
  logic [7:0][MW-1:0]   prod [8];

  logic signed [PW-1:0]    p_d [8][2];
  logic signed [PW-1:0]    p1  [8][2];
  beat_ctl_t               c1;
  logic signed [ACC_W-1:0] s_d [8];
  logic signed [ACC_W-1:0] s2  [8];
  logic                    v2;
  logic signed [OUT_W-1:0] r_d [8];
  logic signed [OUT_W-1:0] o_r [8];

  assign advance = !o_valid || o_ready;
  assign i_ready = advance;

  assign x[0] = i_0;
  assign x[1] = i_1;
  assign x[2] = i_2;
  assign x[3] = i_3;
  assign x[4] = i_4;
  assign x[5] = i_5;
  assign x[6] = i_6;
  assign x[7] = i_7;

  for (genvar j = 0; j < 8; j++) begin : g_sp
    spiral_8_p #(
      .IN_W(IN_W)
    ) u_sp (
      .x(x[j]),
      .m(prod[j])
    );
  end

  // p_d[k][0] sums even columns, p_d[k][1] odd columns of row k.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < 2; h++) begin
        p_d[k][h] = '0;
        for (int t = 0; t < 4; t++) begin
          if (coef_neg(k, 2*t + h))
            p_d[k][h] = p_d[k][h]
              - PW'($signed(prod[2*t+h][coef_idx(k, 2*t + h)]));
          else
            p_d[k][h] = p_d[k][h]
              + PW'($signed(prod[2*t+h][coef_idx(k, 2*t + h)]));
        end
      end
    end
  end

  // C^T[k][j] = (-1)^(k+j) C[k][j]: in inverse mode the partial sum
  // whose column parity differs from k's parity flips sign.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      s_d[k] = '0;
      if (!c1.inverse)
        s_d[k] = ACC_W'(p1[k][0]) + ACC_W'(p1[k][1]);
      else if ((k % 2) == 0)
        s_d[k] = ACC_W'(p1[k][0]) - ACC_W'(p1[k][1]);
      else
        s_d[k] = ACC_W'(p1[k][1]) - ACC_W'(p1[k][0]);
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++)
      r_d[k] = OUT_W'(sat_rnd(64'(s2[k]), SHIFT, OUT_W));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c1      <= '0;
      v2      <= 1'b0;
      o_valid <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        p1[k][0] <= '0;
        p1[k][1] <= '0;
        s2[k]    <= '0;
        o_r[k]   <= '0;
      end
    end else begin
      if (i_flush) begin
        c1.valid <= 1'b0;
        v2       <= 1'b0;
        o_valid  <= 1'b0;
      end else if (advance) begin
        c1.valid <= i_valid;
        v2       <= c1.valid;
        o_valid  <= v2;
      end
      if (advance) begin
        c1.inverse <= i_inverse;
        for (int k = 0; k < 8; k++) begin
          p1[k][0] <= p_d[k][0];
          p1[k][1] <= p_d[k][1];
          s2[k]    <= s_d[k];
          o_r[k]   <= r_d[k];
        end
      end
    end
  end

  assign o_0 = o_r[0];
  assign o_1 = o_r[1];
  assign o_2 = o_r[2];
  assign o_3 = o_r[3];
  assign o_4 = o_r[4];
  assign o_5 = o_r[5];
  assign o_6 = o_r[6];
  assign o_7 = o_r[7];

endmodule

// File: tb/tb_mcm_8_pipe.sv
// Scoreboard bench for mcm_8_pipe: main instance plus narrow-output
// and rounding-shift instances sharing the same stimulus.
module tb_mcm_8_pipe;

  localparam int C [8][8] = '{
    '{  9,  25,  43,  57,  70,  80,  87,  90},
    '{-25, -70, -90, -80, -43,   9,  57,  87},
    '{ 43,  90,  57, -25, -87, -70,   9,  80},
    '{-57, -80,  25,  90,   9, -87, -43,  70},
    '{ 70,  43, -87,  -9,  90, -25, -80,  57},
    '{-80,   9,  70, -87,  25,  57, -90,  43},
    '{ 87, -57,   9,  43, -80,  90, -70,  25},
    '{-90,  87, -80,  70, -57,  43, -25,   9}
  };

  logic clk, rst, i_flush, i_valid, i_inverse, o_ready;
  logic signed [17:0] x [8];
  logic ov_a, ir_a, ov_b, ir_b, ov_c, ir_c;
  logic signed [27:0] oa [8];
  logic signed [19:0] ob [8];
  logic signed [27:0] oc [8];

  int checks = 0;
  int errors = 0;
  logic [511:0] q [$];

  mcm_8_pipe #(.IN_W(18), .SHIFT(0), .OUT_W(28)) dut_a (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_ready(ir_a), .i_inverse(i_inverse),
    .i_0(x[0]), .i_1(x[1]), .i_2(x[2]), .i_3(x[3]),
    .i_4(x[4]), .i_5(x[5]), .i_6(x[6]), .i_7(x[7]),
    .o_valid(ov_a), .o_ready(o_ready),
    .o_0(oa[0]), .o_1(oa[1]), .o_2(oa[2]), .o_3(oa[3]),
    .o_4(oa[4]), .o_5(oa[5]), .o_6(oa[6]), .o_7(oa[7])
  );

  mcm_8_pipe #(.IN_W(18), .SHIFT(0), .OUT_W(20)) dut_b (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_ready(ir_b), .i_inverse(i_inverse),
    .i_0(x[0]), .i_1(x[1]), .i_2(x[2]), .i_3(x[3]),
    .i_4(x[4]), .i_5(x[5]), .i_6(x[6]), .i_7(x[7]),
    .o_valid(ov_b), .o_ready(o_ready),
    .o_0(ob[0]), .o_1(ob[1]), .o_2(ob[2]), .o_3(ob[3]),
    .o_4(ob[4]), .o_5(ob[5]), .o_6(ob[6]), .o_7(ob[7])
  );

  mcm_8_pipe #(.IN_W(18), .SHIFT(4), .OUT_W(28)) dut_c (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_ready(ir_c), .i_inverse(i_inverse),
    .i_0(x[0]), .i_1(x[1]), .i_2(x[2]), .i_3(x[3]),
    .i_4(x[4]), .i_5(x[5]), .i_6(x[6]), .i_7(x[7]),
    .o_valid(ov_c), .o_ready(o_ready),
    .o_0(oc[0]), .o_1(oc[1]), .o_2(oc[2]), .o_3(oc[3]),
    .o_4(oc[4]), .o_5(oc[5]), .o_6(oc[6]), .o_7(oc[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] model(
    input logic signed [17:0] v [8],
    input logic inv,
    input int sh,
    input int ow
  );
    longint s, r, mx, mn;
    logic [511:0] res;
    res = '0;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -(longint'(1) <<< (ow - 1));
    for (int k = 0; k < 8; k++) begin
      s = 0;
      for (int j = 0; j < 8; j++)
        s += longint'(inv ? C[j][k] : C[k][j]) * longint'(v[j]);
      r = (sh > 0) ? ((s + (longint'(1) <<< (sh - 1))) >>> sh) : s;
      if (r > mx) r = mx;
      else if (r < mn) r = mn;
      res[k*64 +: 64] = r;
    end
    return res;
  endfunction

  // Scoreboard: retire outputs, then drop on flush/reset or log accepts.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
    end else begin
      if (ov_a && o_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got o_0=%0d want no beat", oa[0]);
        end else begin
          logic [511:0] e;
          int bad;
          e = q.pop_front();
          bad = -1;
          for (int k = 0; k < 8; k++)
            if (longint'(oa[k]) !== $signed(e[k*64 +: 64]) && bad < 0)
              bad = k;
          if (bad >= 0) begin
            errors++;
            $display("FAIL sb_data o_%0d got %0d want %0d", bad,
                     oa[bad], $signed(e[bad*64 +: 64]));
          end
        end
      end
      if (i_flush)
        q.delete();
      else if (i_valid && ir_a)
        q.push_back(model(x, i_inverse, 0, 28));
    end
  end

  task automatic rand_x();
    for (int j = 0; j < 8; j++)
      x[j] = 18'($urandom);
  endtask

  task automatic set_x(input int v0, input int vr);
    x[0] = 18'(v0);
    for (int j = 1; j < 8; j++)
      x[j] = 18'(vr);
  endtask

  // Presents one beat at posedge+1, returns cycles until o_valid.
  task automatic send_one(input logic inv, output int lat);
    i_inverse = inv;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!ov_a && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_inverse = 1'b0; o_ready = 1'b1;
    set_x(0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov_a !== 1'b0 || ov_b !== 1'b0 || ov_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b%b%b want 000", ov_a, ov_b, ov_c);
    end
    checks++;
    if (ir_a !== 1'b1 || ir_b !== 1'b1 || ir_c !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b%b%b want 111", ir_a, ir_b, ir_c);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (oa[k] !== 28'sd0) begin
        errors++;
        $display("FAIL reset_o_%0d got %0d want 0", k, oa[k]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    int lat;
    int fw [8] = '{9, -25, 43, -57, 70, -80, 87, -90};
    int iv [8] = '{9, 25, 43, 57, 70, 80, 87, 90};
    set_x(1, 0);
    send_one(1'b0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL fwd_latency got %0d want 3", lat);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (longint'(oa[k]) !== longint'(fw[k])) begin
        errors++;
        $display("FAIL impulse_fwd o_%0d got %0d want %0d", k, oa[k], fw[k]);
      end
    end
    send_one(1'b1, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL inv_latency got %0d want 3", lat);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (longint'(oa[k]) !== longint'(iv[k])) begin
        errors++;
        $display("FAIL impulse_inv o_%0d got %0d want %0d", k, oa[k], iv[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_interleave();
    int n, first, last;
    n = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        rand_x();
        i_inverse = c[0];
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (ov_a) begin
        n++;
        if (first < 0) first = c;
        last = c;
      end
    end
    checks++;
    if (n !== 8 || last - first !== 7 || first !== 2) begin
      errors++;
      $display("FAIL interleave_rate got n=%0d first=%0d last=%0d want 8/2/9",
               n, first, last);
    end
  endtask

  task automatic test_all_ones();
    int lat;
    set_x(1, 1);
    send_one(1'b0, lat);
    checks++;
    if (lat !== 3 || oa[0] !== 28'sd461 || oa[1] !== -28'sd155) begin
      errors++;
      $display("FAIL ones_fwd got lat=%0d o_0=%0d o_1=%0d want 3/461/-155",
               lat, oa[0], oa[1]);
    end
    checks++;
    if (oc[0] !== 28'sd29 || oc[1] !== -28'sd10) begin
      errors++;
      $display("FAIL ones_shift4 got o_0=%0d o_1=%0d want 29/-10",
               oc[0], oc[1]);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_extremes();
    int lat;
    set_x(-131072, -131072);
    send_one(1'b0, lat);
    checks++;
    if (ob[0] !== -20'sd524288) begin
      errors++;
      $display("FAIL sat_min got %0d want -524288", ob[0]);
    end
    checks++;
    if (ob[1] !== 20'sd524287) begin
      errors++;
      $display("FAIL sat_max got %0d want 524287", ob[1]);
    end
    checks++;
    if (longint'(oa[0]) !== -64'sd60424192) begin
      errors++;
      $display("FAIL wide_min got %0d want -60424192", oa[0]);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int sent, c, stalls;
    logic acc, prev;
    logic signed [27:0] snap [8];
    sent = 0; c = 0; stalls = 0; prev = 1'b0;
    rand_x();
    i_inverse = 1'b0;
    i_valid = 1'b1;
    while ((sent < 10 || q.size() > 0) && c < 200) begin
      o_ready = !(c >= 5 && c < 10);
      @(negedge clk);
      acc = i_valid && ir_a;
      if (!o_ready && ov_a) begin
        stalls++;
        checks++;
        if (ir_a !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready got %b want 0", ir_a);
        end
        if (prev) begin
          checks++;
          for (int k = 0; k < 8; k++)
            if (oa[k] !== snap[k]) begin
              errors++;
              $display("FAIL stall_hold o_%0d got %0d want %0d",
                       k, oa[k], snap[k]);
              break;
            end
        end
        for (int k = 0; k < 8; k++) snap[k] = oa[k];
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
      @(posedge clk); #1;
      c++;
      if (acc) begin
        sent++;
        if (sent < 10) begin
          rand_x();
          i_inverse = 1'($urandom);
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    o_ready = 1'b1;
    i_valid = 1'b0;
    checks++;
    if (c >= 200 || stalls !== 5) begin
      errors++;
      $display("FAIL bp_drain got cycles=%0d stalls=%0d want <200/5", c, stalls);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    for (int b = 0; b < 3; b++) begin
      rand_x();
      i_inverse = 1'b0;
      i_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    checks++;
    if (ov_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_valid got %b want 1", ov_a);
    end
    rst = 1'b0;
    #1;
    q.delete();
    checks++;
    if (ov_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_valid got %b want 0", ov_a);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (oa[k] !== 28'sd0) begin
        errors++;
        $display("FAIL mid_rst_o_%0d got %0d want 0", k, oa[k]);
      end
    end
    @(negedge clk); #2;
    rst = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ov_a) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_rst_leak got %0d beats want 0", seen);
    end
  endtask

  task automatic test_flush();
    int seen, lat;
    for (int b = 0; b < 2; b++) begin
      rand_x();
      i_inverse = 1'b1;
      i_valid = 1'b1;
      @(posedge clk); #1;
    end
    rand_x();
    i_flush = 1'b1;
    checks++;
    if (ir_a !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got %b want 1", ir_a);
    end
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ov_a) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_leak got %0d beats want 0", seen);
    end
    rand_x();
    send_one(1'b0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL flush_next_latency got %0d want 3", lat);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_interleave();
    test_all_ones();
    test_extremes();
    test_backpressure();
    test_reset_midflight();
    test_flush();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
